c2f_desc_arbiter: RTL and testbench
===================================

C2F_DESC_ARBITER -- requirements
Module: c2f_desc_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of descriptor requesters (2..8).
REQ-002 Parameter DESC_W, default 174: descriptor width, matching the read-data-mover descriptor format.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  NUM_REQ  per-requester descriptor valid.
REQ-006 Port req_data  input  NUM_REQ*DESC_W  per-requester descriptor, flattened, requester i at bits [i*DESC_W +: DESC_W].
REQ-007 Port req_last  input  NUM_REQ  marks the final descriptor of a burst, e.g. low/high wrap pair.
REQ-008 Port req_ready  output  NUM_REQ  per-requester accept.
REQ-009 Port rddm_desc_valid  output  1  descriptor valid toward the read data mover.
REQ-010 Port rddm_desc_data  output  DESC_W  descriptor toward the read data mover.
REQ-011 Port rddm_desc_ready  input  1  read data mover accepts.
REQ-012 Port grant_id  output  $clog2(NUM_REQ)  requester index of the descriptor currently on rddm_desc_data.
REQ-013 Port stat_grant_cnt  output  NUM_REQ*32  per-requester accepted-descriptor counters; see Configuration.

Function
REQ-014 A transfer on either side occurs only in a cycle where valid and ready are both 1.
REQ-015 The output stage is a single register. load_en = !rddm_desc_valid || rddm_desc_ready.
REQ-016 At most one req_ready bit is 1 per cycle, and only while load_en = 1.
REQ-017 req_ready is combinational from req_valid, state and pointer, and is never conditioned on itself.
REQ-018 FSM states: ARB and LOCK.
REQ-019 In ARB: the grant goes to the first valid requester in round-robin order starting at (last_grant+1) mod NUM_REQ.
REQ-020 Accepting a descriptor with req_last=0 moves the FSM ARB->LOCK with owner = that requester.
REQ-021 Accepting a descriptor with req_last=1 keeps the FSM in ARB.
REQ-022 In LOCK: only the owner may receive req_ready, and other requests wait regardless of their valid.
REQ-023 In LOCK, accepting an owner descriptor with req_last=1 returns the FSM to ARB.
REQ-024 last_grant updates to the accepted requester on every accept.
REQ-025 Latency: a descriptor accepted in cycle N appears on rddm_desc_valid/data/grant_id in cycle N+1.
REQ-026 Throughput: one descriptor per cycle when rddm_desc_ready is held at 1.
REQ-027 Simultaneous drain and load in the same cycle replaces the output register with no bubble.
REQ-028 With rddm_desc_ready=0 and the output valid, rddm_desc_data and grant_id hold stable and no requester is granted.
REQ-029 No valid requesters: the output valid falls after the drain, and the pointer and state are unchanged.
REQ-030 Pointer wrap: last_grant = NUM_REQ-1 makes requester 0 highest priority.

Reset
REQ-031 Asserting rst_n low, at any time including mid-LOCK, immediately forces rddm_desc_valid=0, req_ready=0, grant_id=0 and FSM=ARB.
REQ-032 Reset also forces last_grant=NUM_REQ-1, so requester 0 wins first, and clears all stat counters.
REQ-033 rddm_desc_data is don't-care during reset and is not reset.
REQ-034 A burst interrupted by reset is abandoned; requesters restart it.

Configuration
REQ-035 Macro C2F_ARB_STATS_EN defined: each 32-bit stat_grant_cnt slice increments by 1 on each accept from its requester, wrapping at 2^32.
REQ-036 Macro C2F_ARB_STATS_EN undefined: the counters are not built and stat_grant_cnt is tied to 0; all other behaviour is identical.

Structure
REQ-037 The shared struct package holds: the FSM typedef (ARB, LOCK), the C2F_DESC_W=174 constant, and the descriptor field offsets.
REQ-038 One sub-module, rr_arbiter: combinational round-robin select (req vector, pointer -> one-hot grant, index).
REQ-039 rr_arbiter is instantiated once.

Verification
REQ-040 Reset release, req_valid=4'b1111 all last=1, ready=1 -> grants in order 0,1,2,3,0; output valid one cycle after each accept.
REQ-041 Req1 sends last=0 then, 3 cycles later, last=1 while req2 is valid throughout -> both req1 descriptors are consecutive on the output, and req2 is granted only afterwards.
REQ-042 rddm_desc_ready=0 for 5 cycles with output valid, data=174'hA5 -> data/grant_id stable, all req_ready=0; the descriptor transfers in the first ready cycle.
REQ-043 rst_n pulsed low while in LOCK for req3 -> outputs 0 asynchronously; after release with req0 and req3 valid, req0 is granted first.
REQ-044 C2F_ARB_STATS_EN defined, 10 descriptors from req2 -> stat_grant_cnt slice 2 = 10, other slices 0.
REQ-045 C2F_ARB_STATS_EN undefined, same stimulus as REQ-044 -> stat_grant_cnt all 0.

Source files
------------

// File: rtl/c2f_desc_arbiter_pkg.sv
// Shared types and constants for the descriptor arbiter feeding the read data mover.
package c2f_desc_arbiter_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int C2F_DESC_W = 174;

    // Read-data-mover descriptor layout: src | dst | length | control
    localparam int DESC_SRC_OFF  = 0;
    localparam int DESC_SRC_W    = 64;
    localparam int DESC_DST_OFF  = 64;
    localparam int DESC_DST_W    = 64;
    localparam int DESC_LEN_OFF  = 128;
    localparam int DESC_LEN_W    = 24;
    localparam int DESC_CTRL_OFF = 152;
    localparam int DESC_CTRL_W   = 22;

    function automatic logic [DESC_LEN_W-1:0] desc_len(input logic [C2F_DESC_W-1:0] d);
        return d[DESC_LEN_OFF +: DESC_LEN_W];
    endfunction

endpackage

// File: rtl/c2f_desc_arbiter_rr_arbiter.sv
// Combinational round-robin select: first set request after the pointer wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/c2f_desc_arbiter.sv
// Round-robin descriptor arbiter with burst lock and a single output register.
// Optional per-requester accept counters are built when C2F_ARB_STATS_EN is defined.
//
// state | meaning
// ARB   | round-robin among all valid requesters
// LOCK  | mid-burst; only the owner (= last_grant) may be accepted
module c2f_desc_arbiter
    import c2f_desc_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DESC_W  = C2F_DESC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DESC_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rddm_desc_valid,
    output logic [DESC_W-1:0]          rddm_desc_data,
    input  logic                       rddm_desc_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ*32-1:0]      stat_grant_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_last_grant;
    logic                r_out_valid;
    logic [IDX_W-1:0]    r_grant_id;
    logic [DESC_W-1:0]   r_out_data;

    logic                w_load_en;
    logic [NUM_REQ-1:0]  w_owner_mask;
    logic [NUM_REQ-1:0]  w_req_mask;
    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic                w_accept;
    logic                w_acc_last;
    logic [DESC_W-1:0]   w_acc_data;

    // Holding reset in the load enable keeps req_ready low while rst_n is asserted.
    assign w_load_en    = rst_n && (!r_out_valid || rddm_desc_ready);
    assign w_owner_mask = NUM_REQ'(1) << r_last_grant;

    always_comb begin
        w_req_mask = req_valid;
        if (r_state == LOCK) begin
            w_req_mask = req_valid & w_owner_mask;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (w_req_mask),
        .i_ptr   (r_last_grant),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign req_ready  = w_load_en ? w_grant : '0;
    assign w_accept   = w_load_en && w_any;
    assign w_acc_last = req_last[w_idx];
    assign w_acc_data = req_data[w_idx*DESC_W +: DESC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_grant <= w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (w_accept && !w_acc_last) w_state_nxt = LOCK;
            LOCK:    if (w_accept && w_acc_last)  w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_grant_id  <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_grant_id <= w_idx;
            end
        end
    end

    // Payload register carries no reset; valid qualifies it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_out_data <= w_acc_data;
        end
    end

    assign rddm_desc_valid = r_out_valid;
    assign rddm_desc_data  = r_out_data;
    assign grant_id        = r_grant_id;

`ifdef C2F_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [31:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (req_valid[g] && req_ready[g]) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign stat_grant_cnt[g*32 +: 32] = r_cnt;
    end
`else
    assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_c2f_desc_arbiter.sv
// Directed bench for c2f_desc_arbiter (NUM_REQ=4, DESC_W=174).
module tb_c2f_desc_arbiter;

    localparam int N = 4;
    localparam int W = 174;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           rddm_desc_valid;
    logic [W-1:0]   rddm_desc_data;
    logic           rddm_desc_ready;
    logic [1:0]     grant_id;
    logic [N*32-1:0] stat_grant_cnt;

    int checks   = 0;
    int failures = 0;
    logic [N*32-1:0] exp_stat;

    c2f_desc_arbiter #(.NUM_REQ(N), .DESC_W(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .rddm_desc_valid (rddm_desc_valid),
        .rddm_desc_data  (rddm_desc_data),
        .rddm_desc_ready (rddm_desc_ready),
        .grant_id        (grant_id),
        .stat_grant_cnt  (stat_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mkd(input int id, input int seq);
        return W'(id * 256 + seq);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [W-1:0] d);
        req_valid[i]       = v;
        req_last[i]        = l;
        req_data[i*W +: W] = d;
    endtask

    task automatic chk_out(input string tag, input int g, input logic [W-1:0] d);
        chk({tag, "_valid"}, 256'(rddm_desc_valid), 256'd1);
        chk({tag, "_gid"},   256'(grant_id), 256'(g));
        chk({tag, "_data"},  256'(rddm_desc_data), 256'(d));
    endtask

    initial begin
        rst_n = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        rddm_desc_ready = 1'b1;

        // reset state, with requests pending during reset
        #2 rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("rst_valid", 256'(rddm_desc_valid), 256'd0);
        chk("rst_gid",   256'(grant_id), 256'd0);
        chk("rst_ready", 256'(req_ready), 256'd0);
        chk("rst_stat",  256'(stat_grant_cnt), 256'd0);
        tick();
        tick();
        chk("rst_ready_held", 256'(req_ready), 256'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // all four valid, single-beat bursts: 0,1,2,3,0 back to back
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, mkd(i, 0));
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t1_ready", 256'(req_ready), 256'(1 << (k % 4)));
            tick();
            chk_out("t1_out", k % 4, mkd(k % 4, 0));
        end
        req_valid = '0;
        #1 chk("t1_idle_ready", 256'(req_ready), 256'd0);
        tick();
        chk("t1_drain_valid", 256'(rddm_desc_valid), 256'd0);

        // req1 two-beat burst with gap; req2 must wait for it
        set_req(1, 1'b1, 1'b0, mkd(1, 1));
        set_req(2, 1'b1, 1'b1, mkd(2, 1));
        #1 chk("t2_first_ready", 256'(req_ready), 256'b0010);
        tick();
        chk_out("t2_first", 1, mkd(1, 1));
        req_valid[1] = 1'b0;
        #1 chk("t2_lock_hold0", 256'(req_ready), 256'd0);
        tick();
        chk("t2_lock_valid", 256'(rddm_desc_valid), 256'd0);
        #1 chk("t2_lock_hold1", 256'(req_ready), 256'd0);
        tick();
        set_req(1, 1'b1, 1'b1, mkd(1, 2));
        #1 chk("t2_second_ready", 256'(req_ready), 256'b0010);
        tick();
        chk_out("t2_second", 1, mkd(1, 2));
        req_valid[1] = 1'b0;
        #1 chk("t2_req2_ready", 256'(req_ready), 256'b0100);
        tick();
        chk_out("t2_req2", 2, mkd(2, 1));
        req_valid = '0;
        tick();

        // backpressure: output holds A5 for 5 cycles, no grants
        set_req(0, 1'b1, 1'b1, W'(174'hA5));
        #1 chk("t3_load_ready", 256'(req_ready), 256'b0001);
        tick();
        chk_out("t3_load", 0, W'(174'hA5));
        rddm_desc_ready = 1'b0;
        set_req(0, 1'b1, 1'b1, W'(174'hA6));
        set_req(1, 1'b1, 1'b1, mkd(1, 3));
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_stall_ready", 256'(req_ready), 256'd0);
            chk_out("t3_stall", 0, W'(174'hA5));
            tick();
        end
        rddm_desc_ready = 1'b1;
        #1 chk("t3_release_ready", 256'(req_ready), 256'b0010);
        tick();
        chk_out("t3_after", 1, mkd(1, 3));
        req_valid[1] = 1'b0;
        #1 chk("t3_req0_ready", 256'(req_ready), 256'b0001);
        tick();
        chk_out("t3_req0", 0, W'(174'hA6));
        req_valid = '0;
        tick();

        // reset mid-LOCK for req3, then req0 wins first
        set_req(3, 1'b1, 1'b0, mkd(3, 1));
        #1 chk("t4_lock_ready", 256'(req_ready), 256'b1000);
        tick();
        chk_out("t4_lock", 3, mkd(3, 1));
        req_valid[3] = 1'b0;
        set_req(0, 1'b1, 1'b1, mkd(0, 5));
        #1 chk("t4_lock_blocks", 256'(req_ready), 256'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 256'(rddm_desc_valid), 256'd0);
        chk("t4_rst_gid",   256'(grant_id), 256'd0);
        chk("t4_rst_ready", 256'(req_ready), 256'd0);
        tick();
        tick();
        rst_n = 1'b1;
        set_req(3, 1'b1, 1'b1, mkd(3, 2));
        #1 chk("t4_post_ready0", 256'(req_ready), 256'b0001);
        tick();
        chk_out("t4_post0", 0, mkd(0, 5));
        req_valid[0] = 1'b0;
        #1 chk("t4_post_ready3", 256'(req_ready), 256'b1000);
        tick();
        chk_out("t4_post3", 3, mkd(3, 2));
        req_valid = '0;
        tick();

        // stat counters: 10 accepts from req2 after a fresh reset
        rst_n = 1'b0;
        #1 chk("t5_rst_stat", 256'(stat_grant_cnt), 256'd0);
        tick();
        rst_n = 1'b1;
        set_req(2, 1'b1, 1'b1, mkd(2, 9));
        for (int k = 0; k < 10; k++) begin
            #1 chk("t5_ready", 256'(req_ready), 256'b0100);
            tick();
        end
        req_valid = '0;
        #1;
`ifdef C2F_ARB_STATS_EN
        exp_stat = '0;
        exp_stat[64 +: 32] = 32'd10;
`else
        exp_stat = '0;
`endif
        chk("t5_stat", 256'(stat_grant_cnt), 256'(exp_stat));
        chk_out("t5_last", 2, mkd(2, 9));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
